// File: rtl/deser_27b_if.sv
// -----------------------------------------------------------------------------
// deser_27b_if
// Bundles the serial input side and the parallel valid/ready output side of
// the 27-bit deserializer.
//   slave  : view used by deser_27b (consumes data_i/ena_i/ready_i,
//            drives data_o/valid_o/busy_o/err_o/ovf_o)
//   master : view used by whatever drives the stream and consumes the words
// -----------------------------------------------------------------------------
interface deser_27b_if #(
    parameter int WIDTH = 27
);
    logic             data_i;   // serial bit, meaningful only when ena_i = 1
    logic             ena_i;    // bit-valid strobe
    logic             ready_i;  // downstream accepts data_o
    logic [WIDTH-1:0] data_o;   // assembled word
    logic             valid_o;  // data_o holds an unaccepted word
    logic             busy_o;   // a frame is partially received
    logic             err_o;    // one-cycle pulse on gap-timeout abort
    logic             ovf_o;    // sticky: a completed word was dropped

    modport slave (
        input  data_i, ena_i, ready_i,
        output data_o, valid_o, busy_o, err_o, ovf_o
    );

    modport master (
        output data_i, ena_i, ready_i,
        input  data_o, valid_o, busy_o, err_o, ovf_o
    );
endinterface

// File: rtl/deser_27b.sv
// -----------------------------------------------------------------------------
// deser_27b
// Serial-to-parallel receive stage. Reassembles WIDTH-bit words, MSB first,
// from a data/ena bit stream and offers each word on a valid/ready handshake.
// A frame stalled for GAP_MAX idle cycles is aborted (err_o pulse); a word
// completing while the previous one is still pending is dropped (ovf_o).
//
// Ports
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : deser_27b_if.slave (data_i, ena_i, ready_i in;
//            data_o, valid_o, busy_o, err_o, ovf_o out)
// WIDTH must equal the WIDTH of the connected interface instance.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module deser_27b #(
    parameter int WIDTH   = 27,
    parameter int GAP_MAX = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    deser_27b_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = $clog2(GAP_MAX);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_MAX - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic [GW-1:0]    gap_cnt, gap_cnt_n;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             err_q;
    logic             ovf_q;
    logic             word_done;
    logic             abort;

    // Value the shift register takes if a bit is sampled this edge; on the
    // final bit this is also the completed word.
    assign sr_next = {sr[WIDTH-2:0], bus.data_i};

    // -------------------------------------------------------------------------
    // Next-state / counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_n   = state;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        word_done = 1'b0;
        abort     = 1'b0;

        unique case (state)
            IDLE: begin
                gap_cnt_n = '0;
                if (bus.ena_i) begin
                    bit_cnt_n = CW'(1);
                    state_n   = SHIFT;
                end
            end

            SHIFT: begin
                if (bus.ena_i) begin
                    gap_cnt_n = '0;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end else if (gap_cnt == LAST_GAP) begin
                    // Too long without a bit: discard the partial frame.
                    bit_cnt_n = '0;
                    gap_cnt_n = '0;
                    state_n   = IDLE;
                    abort     = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from the pre-edge values of all the others.
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the shift register is reset too, so data_o can never
            // expose bits from a frame that straddled a reset.
            sr      <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt_n;
            gap_cnt <= gap_cnt_n;
            err_q   <= abort;

            if (bus.ena_i) begin
                sr <= sr_next;
            end

            // A pending word leaves on a transfer; a completed word takes its
            // place if the slot is free or being freed on this same edge.
            if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end

            if (word_done) begin
                if (!valid_q || bus.ready_i) begin
                    data_q  <= sr_next;
                    valid_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = (state == SHIFT);
    assign bus.err_o   = err_q;
    assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_deser_27b.sv
// -----------------------------------------------------------------------------
// tb_deser_27b
// Self-checking bench for deser_27b. Inputs change 1 ns after the rising edge;
// transfers are scored at the falling edge, where inputs and outputs are both
// stable, against a queue of expected words filled as frames are sent.
// -----------------------------------------------------------------------------
module tb_deser_27b;

    localparam int W = 27;

    typedef struct {
        logic [W-1:0] word;
        int           gap;   // idle cycles inserted between consecutive bits
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [W-1:0] sb_q[$];

    deser_27b_if #(.WIDTH(W)) bus ();

    deser_27b #(
        .WIDTH  (W),
        .GAP_MAX(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Score a transfer that the coming rising edge will perform.
    task automatic monitor();
        logic [W-1:0] exp;
        if (!rst && bus.valid_o && bus.ready_i) begin
            if (sb_q.size() == 0) begin
                check("unexpected_xfer", 32'(bus.data_o), 32'hDEAD_BEEF);
            end else begin
                exp = sb_q.pop_front();
                check("xfer_data", 32'(bus.data_o), 32'(exp));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(bus.data_o), 32'h0);
        check({tag, "_valid"}, 32'(bus.valid_o), 32'h0);
        check({tag, "_busy"},  32'(bus.busy_o), 32'h0);
        check({tag, "_err"},   32'(bus.err_o), 32'h0);
        check({tag, "_ovf"},   32'(bus.ovf_o), 32'h0);
    endtask

    // Send the top nbits of w, MSB first. busy_o must be 1 after every edge
    // except the one completing a full word; err_o must stay 0 throughout.
    task automatic send_bits(input logic [W-1:0] w, input int nbits, input int gap,
                             input bit ready_on_last);
        int busy_bad;
        int err_bad;
        logic exp_busy;
        busy_bad = 0;
        err_bad  = 0;
        for (int i = 0; i < nbits; i++) begin
            bus.ena_i  = 1'b1;
            bus.data_i = w[W-1-i];
            if (ready_on_last && i == nbits - 1) bus.ready_i = 1'b1;
            step();
            bus.ena_i  = 1'b0;
            bus.data_i = 1'b0;
            exp_busy = !(nbits == W && i == W - 1);
            if (bus.busy_o !== exp_busy) busy_bad++;
            if (bus.err_o !== 1'b0) err_bad++;
            if (i != nbits - 1) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    if (bus.busy_o !== 1'b1) busy_bad++;
                    if (bus.err_o !== 1'b0) err_bad++;
                end
            end
        end
        check("frame_busy", 32'(busy_bad), 32'h0);
        check("frame_err_quiet", 32'(err_bad), 32'h0);
    endtask

    vec_t vecs[5];

    initial begin
        int bad;
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.data_i  = 1'b0;
        bus.ena_i   = 1'b0;
        bus.ready_i = 1'b0;

        vecs[0] = '{word: 27'h2ABCDEF, gap: 0};
        vecs[1] = '{word: 27'h5555555, gap: 15};
        vecs[2] = '{word: 27'h0000001, gap: 0};
        vecs[3] = '{word: 27'h1A2B3C4, gap: 1};
        vecs[4] = '{word: 27'h7000001, gap: 7};

        // Reset state
        do_reset();
        check_all_zero("reset");

        // Table: contiguous and gapped frames with a ready consumer.
        // valid_o must be high for exactly the one cycle after the last bit.
        bus.ready_i = 1'b1;
        foreach (vecs[k]) begin
            sb_q.push_back(vecs[k].word);
            send_bits(vecs[k].word, W, vecs[k].gap, 1'b0);
            check("tbl_valid_hi", 32'(bus.valid_o), 32'h1);
            step();
            check("tbl_valid_lo", 32'(bus.valid_o), 32'h0);
            check("tbl_ovf", 32'(bus.ovf_o), 32'h0);
        end
        check("tbl_sb_empty", 32'(sb_q.size()), 32'h0);

        // Timeout abort: 10 bits then 16 idle cycles
        send_bits(27'h5A5A5A5, 10, 0, 1'b0);
        bad = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1) bad++;
        end
        check("gap_tolerated", 32'(bad), 32'h0);
        step();
        check("abort_err", 32'(bus.err_o), 32'h1);
        check("abort_busy", 32'(bus.busy_o), 32'h0);
        check("abort_valid", 32'(bus.valid_o), 32'h0);
        step();
        check("abort_err_pulse", 32'(bus.err_o), 32'h0);
        sb_q.push_back(27'h0000001);
        send_bits(27'h0000001, W, 0, 1'b0);
        check("post_abort_valid", 32'(bus.valid_o), 32'h1);
        step();
        check("post_abort_sb", 32'(sb_q.size()), 32'h0);

        // Stall and overflow: two back-to-back words into a stalled consumer
        bus.ready_i = 1'b0;
        sb_q.push_back(27'h7FFFFFF);
        send_bits(27'h7FFFFFF, W, 0, 1'b0);
        check("ovf_before_drop", 32'(bus.ovf_o), 32'h0);
        send_bits(27'h1234567, W, 0, 1'b0);
        check("stall_data", 32'(bus.data_o), 32'h7FFFFFF);
        check("stall_valid", 32'(bus.valid_o), 32'h1);
        check("stall_ovf", 32'(bus.ovf_o), 32'h1);
        bus.ready_i = 1'b1;
        step();
        check("drain_valid", 32'(bus.valid_o), 32'h0);
        check("drain_sb", 32'(sb_q.size()), 32'h0);
        step();
        check("ovf_sticky", 32'(bus.ovf_o), 32'h1);

        // Accept and complete on the same edge
        do_reset();
        bus.ready_i = 1'b0;
        sb_q.push_back(27'h1111111);
        sb_q.push_back(27'h0F0F0F0);
        send_bits(27'h1111111, W, 0, 1'b0);
        send_bits(27'h0F0F0F0, W, 0, 1'b1);
        check("same_edge_valid", 32'(bus.valid_o), 32'h1);
        check("same_edge_data", 32'(bus.data_o), 32'h0F0F0F0);
        check("same_edge_ovf", 32'(bus.ovf_o), 32'h0);
        check("same_edge_sb", 32'(sb_q.size()), 32'h1);
        step();
        check("same_edge_drain", 32'(bus.valid_o), 32'h0);

        // Reset mid-frame with ovf_o set and a word pending
        bus.ready_i = 1'b0;
        sb_q.push_back(27'h0ABCDEF);
        send_bits(27'h0ABCDEF, W, 0, 1'b0);
        send_bits(27'h0000F00, W, 0, 1'b0);
        check("pre_rst_ovf", 32'(bus.ovf_o), 32'h1);
        send_bits(27'h7654321, 13, 0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        check_all_zero("mid_rst");
        bus.ready_i = 1'b1;
        sb_q.push_back(27'h3C3C3C3);
        send_bits(27'h3C3C3C3, W, 0, 1'b0);
        check("post_rst_data", 32'(bus.data_o), 32'h3C3C3C3);
        step();
        check("post_rst_valid", 32'(bus.valid_o), 32'h0);
        check("final_sb_empty", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deser_27b.md
# deser_27b

Serial-to-parallel receive stage that sits directly downstream of the 27-bit serializer. It consumes the serializer's `data_o`/`ena_o` bit stream and reassembles 27-bit words, MSB first. It presents each word on a valid/ready handshake to the next stage. It recovers from truncated frames by idle-gap timeout and flags words dropped because the consumer stalled.

## Interface

**Parameters**
- `WIDTH`, default 27: bits per word. Must match the serializer word width.
- `GAP_MAX`, default 16: number of consecutive idle cycles (`ena_i`=0) mid-frame that aborts the frame. Minimum 2.

**Ports**
- `clk_i`  in  1: single clock. All logic samples on the rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `data_i`  in  1: serial bit. Driven from the serializer's `data_o`.
- `ena_i`  in  1: bit-valid strobe. Driven from the serializer's `ena_o`. `data_i` is sampled only when `ena_i`=1.
- `ready_i`  in  1: the downstream stage accepts `data_o`.
- `data_o`  out  WIDTH: assembled word. Held stable while `valid_o`=1.
- `valid_o`  out  1: `data_o` holds an unaccepted word.
- `busy_o`  out  1: a frame is partially received (state SHIFT).
- `err_o`  out  1: one-cycle pulse when a frame is aborted by gap timeout.
- `ovf_o`  out  1: sticky flag, set when a completed word is dropped. Cleared only by `rst_i`.

## Operation

**Datapath**
- Shift register `sr[WIDTH-1:0]`.
- Bit counter `bit_cnt`, 0..WIDTH-1.
- Gap counter `gap_cnt`, 0..GAP_MAX-1.
- Output holding register feeding `data_o`.

**Bit order**
- The first sampled bit is the MSB. On each edge with `ena_i`=1: `sr <= {sr[WIDTH-2:0], data_i}`.

**State IDLE** (`bit_cnt`=0, `busy_o`=0)
- Edge with `ena_i`=1: shift in the bit, `bit_cnt`<=1, go to SHIFT.
- Otherwise stay in IDLE. `gap_cnt` is held at 0.

**State SHIFT** (`busy_o`=1)
- Edge with `ena_i`=1, `gap_cnt`<=0, shift in the bit:
  - If `bit_cnt`=WIDTH-1, the word is complete: `bit_cnt`<=0, go to IDLE, apply the load rule below.
  - Otherwise `bit_cnt`<=`bit_cnt`+1.
- Edge with `ena_i`=0:
  - If `gap_cnt`=GAP_MAX-1: abort. `bit_cnt`<=0, `gap_cnt`<=0, go to IDLE, `err_o`=1 for the next cycle. The partial word is discarded.
  - Otherwise `gap_cnt`<=`gap_cnt`+1.

**Load rule** (on word completion, using the completed value `{sr[WIDTH-2:0], data_i}`)
- If `valid_o`=0, or `valid_o`=1 and `ready_i`=1 on the same edge: load `data_o`, `valid_o`<=1.
- If `valid_o`=1 and `ready_i`=0: drop the new word, `data_o` unchanged, `ovf_o`<=1.

**Handshake**
- A transfer occurs on an edge where `valid_o`=1 and `ready_i`=1.
- After a transfer, `valid_o`<=0 unless a word is loaded on the same edge.
- `ready_i` has no effect while `valid_o`=0.
- `ready_i` may depend combinationally on `valid_o`. `valid_o` must not depend combinationally on `ready_i`.

**Reset** (`rst_i`=1 at an edge, including mid-frame)
- Go to IDLE. `sr`, `bit_cnt`, `gap_cnt` <= 0.
- `data_o`=0, `valid_o`=0, `busy_o`=0, `err_o`=0, `ovf_o`=0.
- Any partial or pending word is discarded. Reset has priority over all other events.

## Timing

- All outputs are registered. No combinational input-to-output paths.
- Latency: when the last bit is sampled at edge N, `data_o`/`valid_o` are visible from N+1.
- Back-to-back frames: a new frame's MSB may be sampled at edge N+1. No dead cycle is required.
- Gap tolerance: up to GAP_MAX-1 consecutive idle cycles inside a frame are tolerated. The GAP_MAX-th idle edge aborts the frame.
- If `ena_i`=1 on the edge where the abort would otherwise occur, the bit is sampled normally and there is no abort.
- `err_o` and `ovf_o` first go high in the cycle after the triggering edge.
- Minimum word period is WIDTH cycles. With a permanently ready consumer, throughput is one word per WIDTH cycles.

## Test plan

1. **Contiguous frame.** Reset, `ready_i`=1, 27 contiguous bits of 27'h2ABCDEF, MSB first. Required: `valid_o`=1 for exactly one cycle, one cycle after the 27th sampling edge. `data_o`=27'h2ABCDEF. `busy_o`=1 from the first-bit edge until the last-bit edge. `err_o`=`ovf_o`=0.
2. **Gapped stream.** Frame of 27'h5555555 with 15 idle cycles between every bit. Required: correct word, no `err_o`.
3. **Timeout abort.** 10 bits, then 16 idle cycles. Required: `err_o` pulses for one cycle after the 16th idle edge, `busy_o`->0, `valid_o` stays 0. A following full frame of 27'h0000001 is received as 27'h0000001.
4. **Stall and overflow.** `ready_i`=0, send 27'h7FFFFFF then 27'h1234567 back-to-back. Required: `data_o` stays 27'h7FFFFFF with `valid_o`=1, and `ovf_o`=1 from the cycle after the second word completes. After raising `ready_i`, one transfer of 27'h7FFFFFF, then `valid_o`=0.
5. **Accept and complete on the same edge.** `ready_i` rises on the very edge the second word (27'h0F0F0F0) completes while the first is pending. Required: `valid_o` stays 1, `data_o`=27'h0F0F0F0, `ovf_o`=0.
6. **Reset mid-frame.** `rst_i` after 13 bits with `ovf_o` previously set. Required: all outputs 0 on the next cycle. The next full frame of 27'h3C3C3C3 decodes correctly.
